// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage.
// Op codes and divider states.
package exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_PASSB = 4'd10,
    OP_DIVU  = 4'd11,
    OP_DIV   = 4'd12
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_e;

endpackage

// File: rtl/exec_unit_mc_divider.sv
// Iterative restoring divider, one quotient bit per clock.
// done/quotient/rem are valid in the last BUSY cycle.
module iter_divider
  import exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e     state;
  logic [CW-1:0]  count;
  logic [WIDTH-1:0] q, r, d;
  logic           negq, negr;

  logic [WIDTH-1:0] amag, bmag;
  logic [WIDTH:0]   r_sh, diff;
  logic [WIDTH-1:0] q_nx, r_nx;

  assign amag = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign bmag = (signed_mode && b[WIDTH-1]) ? -b : b;

  always_comb begin
    r_sh = {r, q[WIDTH-1]};
    diff = r_sh - {1'b0, d};
    if (!diff[WIDTH]) begin
      r_nx = diff[WIDTH-1:0];
      q_nx = {q[WIDTH-2:0], 1'b1};
    end else begin
      r_nx = r_sh[WIDTH-1:0];
      q_nx = {q[WIDTH-2:0], 1'b0};
    end
  end

  assign busy     = (state == BUSY);
  assign done     = busy && (count == CW'(1));
  assign quotient = negq ? -q_nx : q_nx;
  assign rem      = negr ? -r_nx : r_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      q     <= '0;
      r     <= '0;
      d     <= '0;
      negq  <= 1'b0;
      negr  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state <= BUSY;
          count <= CW'(WIDTH);
          q     <= amag;
          r     <= '0;
          d     <= bmag;
          negq  <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
          negr  <= signed_mode && a[WIDTH-1];
        end
        BUSY: begin
          q     <= q_nx;
          r     <= r_nx;
          count <= count - CW'(1);
          if (count == CW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/exec_unit_mc.sv
// Execute stage: forwarding muxes, single-cycle ALU,
// iterative divider with stall, registered writeback.
module exec_unit_mc
  import exec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             fwd_a,
  input  logic             fwd_b,
  input  logic [WIDTH-1:0] fwd_data_a,
  input  logic [WIDTH-1:0] fwd_data_b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] data_a_out,
  output logic             out_valid,
  output logic             zero_flag,
  output logic             div_by_zero,
  output logic             stall
);

  logic [WIDTH-1:0] opa, opb, alu;
  logic             accept, is_div, b_zero, div_start;
  logic             div_busy, div_done;
  logic [WIDTH-1:0] div_q, div_r;
  logic             wb_en, wb_dbz;
  logic [WIDTH-1:0] wb_res, wb_rem;

  assign opa       = fwd_a ? fwd_data_a : data_a;
  assign opb       = fwd_b ? fwd_data_b : data_b;
  assign accept    = in_valid && !stall;
  assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign b_zero    = (opb == '0);
  assign div_start = accept && is_div && !b_zero;
  assign stall     = div_busy;

  always_comb begin
    alu = opb;
    unique case (op)
      OP_ADD:  alu = opa + opb;
      OP_SUB:  alu = opa - opb;
      OP_AND:  alu = opa & opb;
      OP_OR:   alu = opa | opb;
      OP_XOR:  alu = opa ^ opb;
      OP_SLL:  alu = opa << opb[SHW-1:0];
      OP_SRL:  alu = opa >> opb[SHW-1:0];
      OP_SRA:  alu = WIDTH'($signed(opa) >>> opb[SHW-1:0]);
      OP_SLT:  alu = {{(WIDTH-1){1'b0}}, $signed(opa) < $signed(opb)};
      OP_SLTU: alu = {{(WIDTH-1){1'b0}}, opa < opb};
      default: alu = opb;
    endcase
  end

  // Divide-by-zero completes like a single-cycle op.
  always_comb begin
    wb_en  = 1'b0;
    wb_res = alu;
    wb_rem = '0;
    wb_dbz = 1'b0;
    if (div_done) begin
      wb_en  = 1'b1;
      wb_res = div_q;
      wb_rem = div_r;
    end else if (accept && is_div && b_zero) begin
      wb_en  = 1'b1;
      wb_res = '1;
      wb_rem = opa;
      wb_dbz = 1'b1;
    end else if (accept && !is_div) begin
      wb_en  = 1'b1;
    end
  end

  iter_divider #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .rst_n       (rst),
    .start       (div_start),
    .signed_mode (op == OP_DIV),
    .a           (opa),
    .b           (opb),
    .busy        (div_busy),
    .done        (div_done),
    .quotient    (div_q),
    .rem         (div_r)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result      <= '0;
      remainder   <= '0;
      data_a_out  <= '0;
      out_valid   <= 1'b0;
      zero_flag   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      out_valid <= wb_en;
      if (accept) data_a_out <= data_a;
      if (wb_en) begin
        result      <= wb_res;
        remainder   <= wb_rem;
        div_by_zero <= wb_dbz;
        zero_flag   <= (wb_res == '0);
      end
    end
  end

endmodule
